// File: rtl/endec_ctrl.sv
// endec_ctrl: job sequencer for the encode/decode datapath; drives per-stage enables from one FSM.
// Optional watchdog abort is enabled by defining ENDEC_CTRL_WATCHDOG_EN.
module endec_ctrl #(
    parameter int FRAME_STEPS = 192,
    parameter int WDOG_LIMIT  = 255
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       en,
    input  logic       i_start,
    input  logic       i_mode_sel,
    input  logic       ood,
    input  logic       td_full,
    input  logic       td_empty,
    output logic       en_ce,
    output logic       en_s,
    output logic       en_bm,
    output logic       en_acs,
    output logic       en_td,
    output logic       en_t,
    output logic       o_ready,
    output logic       o_busy,
    output logic       o_done,
    output logic       o_err,
    output logic [7:0] o_step_cnt
);
    typedef enum logic [2:0] {IDLE, CFG, ENC, DEC, DRAIN, TRACE, DONE} state_t;
    localparam logic [7:0] FS = 8'(FRAME_STEPS);

    state_t     st_q, st_d;
    logic [7:0] cnt_q, cnt_d, cnt_inc;
    logic [2:0] sr_q, sr_d;
    logic       mode_q, mode_d, err_q, err_d, emp_q, emp_d;
    logic       run, pipe, issue, abort;

`ifdef ENDEC_CTRL_WATCHDOG_EN
    localparam logic [7:0] WL = 8'(WDOG_LIMIT);
    logic [7:0] wd_q, wd_d;
    logic       wd_cond;
    always_comb begin
        wd_cond = (st_q == TRACE && !td_empty) || ((st_q == DEC || st_q == DRAIN) && td_full);
        wd_d    = !en ? wd_q : (wd_cond ? wd_q + 8'd1 : '0);
        abort   = en && wd_cond && (wd_q + 8'd1 == WL);
    end
    always_ff @(posedge sys_clk) wd_q <= rst ? '0 : wd_d;
`else
    assign abort = 1'b0;
`endif

    always_comb begin
        run     = en && !rst;
        pipe    = st_q == DEC || st_q == DRAIN;
        issue   = st_q == DEC && cnt_q < FS && !ood && !td_full;
        cnt_inc = (cnt_q == 8'hff) ? cnt_q : cnt_q + 8'd1;
        // bit0/1/2 of the shift register feed branch metric, ACS and traceback write
        sr_d    = !en ? sr_q : (!pipe ? '0 : (td_full ? sr_q : {sr_q[1:0], issue}));
        emp_d   = en ? td_empty : emp_q;
        st_d    = st_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        err_d   = err_q;
        if (en) begin
            case (st_q)
                IDLE: if (i_start) begin
                    st_d   = CFG;
                    mode_d = i_mode_sel;
                    cnt_d  = '0;
                    err_d  = 1'b0;
                end
                CFG: st_d = mode_q ? DEC : ENC;
                ENC: begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == FS) st_d = DONE;
                end
                DEC: begin
                    if (issue) cnt_d = cnt_inc;
                    if (cnt_q == FS || ood) st_d = DRAIN;
                end
                DRAIN: if (!td_full && sr_q[1:0] == 2'b00) st_d = TRACE;
                TRACE: if (emp_q) st_d = DONE;
                default: st_d = IDLE;
            endcase
            if (abort) begin
                st_d  = DONE;
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            st_q   <= IDLE;
            cnt_q  <= '0;
            sr_q   <= '0;
            mode_q <= 1'b0;
            err_q  <= 1'b0;
            emp_q  <= 1'b0;
        end else begin
            st_q   <= st_d;
            cnt_q  <= cnt_d;
            sr_q   <= sr_d;
            mode_q <= mode_d;
            err_q  <= err_d;
            emp_q  <= emp_d;
        end
    end

    assign en_ce      = run && (st_q == CFG || st_q == ENC);
    assign en_s       = run && issue;
    assign en_bm      = run && pipe && !td_full && sr_q[0];
    assign en_acs     = run && pipe && !td_full && sr_q[1];
    assign en_td      = run && pipe && !td_full && sr_q[2];
    assign en_t       = run && st_q == TRACE;
    assign o_ready    = rst || st_q == IDLE;
    assign o_busy     = !o_ready;
    assign o_done     = run && st_q == DONE;
    assign o_err      = err_q && !rst;
    assign o_step_cnt = cnt_q;
endmodule

// File: tb/tb_endec_ctrl.sv
// tb_endec_ctrl: directed jobs against a step-queue model of the controller, plus literal timing checks.
module tb_endec_ctrl;
    localparam int FS = 192, WL = 10;
    localparam int P_IDLE = 0, P_CFG = 1, P_ENC = 2, P_DEC = 3, P_DRAIN = 4, P_TRACE = 5, P_DONE = 6;

    logic sys_clk = 0, rst = 1, en = 1, i_start = 0, i_mode_sel = 0, ood = 0, td_full = 0, td_empty = 0;
    logic en_ce, en_s, en_bm, en_acs, en_td, en_t, o_ready, o_busy, o_done, o_err;
    logic [7:0] o_step_cnt;
    logic e_start = 0, zero = 0;
    logic x_ce, x_s, x_bm, x_acs, x_td, x_t, x_ready, x_busy, x_done, x_err;
    logic [7:0] x_cnt;
    int checks = 0, failures = 0;

    always #5 sys_clk = ~sys_clk;

    endec_ctrl #(.FRAME_STEPS(FS), .WDOG_LIMIT(WL)) dut (
        .sys_clk(sys_clk), .rst(rst), .en(en), .i_start(i_start), .i_mode_sel(i_mode_sel),
        .ood(ood), .td_full(td_full), .td_empty(td_empty),
        .en_ce(en_ce), .en_s(en_s), .en_bm(en_bm), .en_acs(en_acs), .en_td(en_td), .en_t(en_t),
        .o_ready(o_ready), .o_busy(o_busy), .o_done(o_done), .o_err(o_err), .o_step_cnt(o_step_cnt)
    );

    endec_ctrl #(.FRAME_STEPS(4), .WDOG_LIMIT(WL)) dut_enc (
        .sys_clk(sys_clk), .rst(rst), .en(en), .i_start(e_start), .i_mode_sel(zero),
        .ood(zero), .td_full(zero), .td_empty(zero),
        .en_ce(x_ce), .en_s(x_s), .en_bm(x_bm), .en_acs(x_acs), .en_td(x_td), .en_t(x_t),
        .o_ready(x_ready), .o_busy(x_busy), .o_done(x_done), .o_err(x_err), .o_step_cnt(x_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: job phase, issued step count, and a queue of in-flight steps tagged by advances taken
    int ph = P_IDLE, steps = 0, wd = 0;
    bit mode = 0, merr = 0, seen = 0;
    int mq[$];

    function automatic bit has_age(input int a);
        foreach (mq[i]) if (mq[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [17:0] model_out();
        bit run, pipe;
        run  = en && !rst;
        pipe = ph == P_DEC || ph == P_DRAIN;
        return {rst || ph == P_IDLE, !rst && ph != P_IDLE, run && ph == P_DONE, merr && !rst,
                run && (ph == P_CFG || ph == P_ENC), run && ph == P_DEC && steps < FS && !ood && !td_full,
                run && pipe && !td_full && has_age(1), run && pipe && !td_full && has_age(2),
                run && pipe && !td_full && has_age(3), run && ph == P_TRACE, 8'(steps)};
    endfunction

    task automatic model_step();
        int nph;
        bit issue;
        int nq[$];
        if (rst) begin
            ph = P_IDLE; steps = 0; mode = 0; merr = 0; wd = 0; seen = 0;
            mq.delete();
        end else if (en) begin
            issue = ph == P_DEC && steps < FS && !ood && !td_full;
            nph = ph;
            if ((ph == P_DEC || ph == P_DRAIN) && !td_full) begin
                foreach (mq[i]) if (mq[i] < 3) nq.push_back(mq[i] + 1);
                if (issue) nq.push_back(1);
                mq = nq;
            end
            case (ph)
                P_IDLE: if (i_start) begin nph = P_CFG; mode = i_mode_sel; steps = 0; merr = 0; end
                P_CFG: nph = mode ? P_DEC : P_ENC;
                P_ENC: begin steps = steps < 255 ? steps + 1 : 255; if (steps == FS) nph = P_DONE; end
                P_DEC: begin
                    if (steps == FS || ood) nph = P_DRAIN;
                    if (issue) steps = steps < 255 ? steps + 1 : 255;
                end
                P_DRAIN: if (!td_full && mq.size() == 0) nph = P_TRACE;
                P_TRACE: if (seen) nph = P_DONE;
                default: nph = P_IDLE;
            endcase
`ifdef ENDEC_CTRL_WATCHDOG_EN
            if ((ph == P_TRACE && !td_empty) || ((ph == P_DEC || ph == P_DRAIN) && td_full)) begin
                wd++;
                if (wd == WL) begin nph = P_DONE; merr = 1; mq.delete(); end
            end else wd = 0;
`endif
            seen = td_empty;
            ph = nph;
        end
    endtask

    initial begin
        @(posedge sys_clk);
        forever begin
            @(negedge sys_clk);
            chk("cycle_outputs",
                32'({o_ready, o_busy, o_done, o_err, en_ce, en_s, en_bm, en_acs, en_td, en_t, o_step_cnt}),
                32'(model_out()));
            model_step();
        end
    end

    int n_ce, n_s, n_td, n_t, first_s, last_s, first_td, last_td, first_t, ce_last, done_c, stall_s;
    logic [7:0] cnt_done, rst_snap;
    logic err_done;

    task automatic run_job(input bit dec, input int empty_at, input int full_from, input int full_len,
                           input int ood_from, input int rst_at, input int restart_at,
                           input int off_from, input int off_len, input int max_c);
        n_ce = 0; n_s = 0; n_td = 0; n_t = 0; stall_s = 0; ce_last = -1;
        first_s = -1; last_s = -1; first_td = -1; last_td = -1; first_t = -1; done_c = -1;
        cnt_done = 0; err_done = 0; rst_snap = 0;
        for (int c = 0; c < max_c; c++) begin
            i_start    = c == 0 || c == restart_at;
            i_mode_sel = dec;
            td_empty   = empty_at >= 0 && c >= empty_at;
            td_full    = c >= full_from && c < full_from + full_len;
            ood        = ood_from >= 0 && c >= ood_from;
            rst        = c == rst_at;
            en         = !(c >= off_from && c < off_from + off_len);
            @(negedge sys_clk);
            if (en_ce) begin n_ce++; ce_last = c; end
            if (en_s) begin n_s++; if (first_s < 0) first_s = c; last_s = c; end
            if (en_td) begin n_td++; if (first_td < 0) first_td = c; last_td = c; end
            if (en_t) begin n_t++; if (first_t < 0) first_t = c; end
            if (td_full && (en_s || en_bm || en_acs || en_td)) stall_s++;
            if (o_done) begin done_c = c; cnt_done = o_step_cnt; err_done = o_err; end
            if (rst_at >= 0 && c == rst_at + 1)
                rst_snap = {o_ready, o_busy, en_ce, en_s, en_bm, en_acs, en_td, en_t};
            @(posedge sys_clk); #1;
            if (done_c >= 0) break;
        end
        i_start = 0; td_empty = 0; td_full = 0; ood = 0; rst = 0; en = 1;
    endtask

    initial begin
        int e_n, e_first, e_last, e_done, e_dec;
        logic [7:0] e_cnt;
        repeat (2) @(posedge sys_clk);
        #1;
        @(negedge sys_clk);
        chk("reset_ready", 32'(o_ready), 1);
        chk("reset_outs", 32'({o_busy, o_done, o_err, en_ce, en_s, en_bm, en_acs, en_td, en_t}), 0);
        chk("reset_cnt", 32'(o_step_cnt), 0);
        @(posedge sys_clk); #1;
        rst = 0;

        run_job(1, 200, -1, 0, -1, -1, -1, -1, 0, 260);
        chk("dec_ce_count", n_ce, 1);
        chk("dec_ce_cycle", ce_last, 1);
        chk("dec_first_s", first_s, 2);
        chk("dec_last_s", last_s, 193);
        chk("dec_n_s", n_s, 192);
        chk("dec_first_td", first_td, 5);
        chk("dec_last_td", last_td, 196);
        chk("dec_first_t", first_t, 197);
        chk("dec_done", done_c, 202);
        chk("dec_cnt", 32'(cnt_done), 192);
        chk("dec_err", 32'(err_done), 0);

        run_job(0, -1, -1, 0, -1, -1, -1, -1, 0, 260);
        chk("enc192_ce", n_ce, 193);
        chk("enc192_done", done_c, 194);
        chk("enc192_cnt", 32'(cnt_done), 192);
        chk("enc192_dec_en", n_s + n_td + n_t, 0);

        e_n = 0; e_first = -1; e_last = -1; e_done = -1; e_dec = 0; e_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            e_start = c == 0;
            @(negedge sys_clk);
            if (x_ce) begin e_n++; if (e_first < 0) e_first = c; e_last = c; end
            if (x_s || x_bm || x_acs || x_td || x_t) e_dec++;
            if (x_done && e_done < 0) begin e_done = c; e_cnt = x_cnt; end
            @(posedge sys_clk); #1;
        end
        chk("enc4_ce_count", e_n, 5);
        chk("enc4_ce_first", e_first, 1);
        chk("enc4_ce_last", e_last, 5);
        chk("enc4_done", e_done, 6);
        chk("enc4_cnt", 32'(e_cnt), 4);
        chk("enc4_dec_en", e_dec, 0);

        run_job(1, 200, 50, 3, -1, -1, -1, -1, 0, 260);
        chk("stall_quiet", stall_s, 0);
        chk("stall_n_s", n_s, 192);
        chk("stall_n_td", n_td, 192);
        chk("stall_last_s", last_s, 196);
        chk("stall_last_td", last_td, 199);
        chk("stall_first_t", first_t, 200);
        chk("stall_done", done_c, 202);

        run_job(1, 55, -1, 0, 52, -1, -1, -1, 0, 120);
        chk("ood_n_s", n_s, 50);
        chk("ood_n_td", n_td, 50);
        chk("ood_last_td", last_td, 54);
        chk("ood_first_t", first_t, 55);
        chk("ood_done", done_c, 57);
        chk("ood_cnt", 32'(cnt_done), 50);

        run_job(1, 205, -1, 0, -1, -1, -1, 100, 5, 270);
        chk("pause_n_s", n_s, 192);
        chk("pause_last_s", last_s, 198);
        chk("pause_first_t", first_t, 202);
        chk("pause_done", done_c, 207);

        run_job(1, -1, -1, 0, -1, 200, 198, -1, 0, 206);
        chk("rst_trace_next", 32'(rst_snap), 32'h80);
        chk("busy_start_ignored", n_ce, 1);
        chk("rst_no_done", done_c, -1);

        run_job(1, -1, -1, 0, -1, -1, -1, -1, 0, 240);
`ifdef ENDEC_CTRL_WATCHDOG_EN
        chk("wdog_done", done_c, 207);
        chk("wdog_err", 32'(err_done), 1);
        chk("wdog_trace_cycles", n_t, 10);
`else
        chk("nowdog_no_done", done_c, -1);
        chk("nowdog_trace_cycles", n_t, 43);
        @(negedge sys_clk);
        chk("nowdog_still_trace", 32'({o_busy, en_t, o_err}), 32'b110);
`endif
        @(posedge sys_clk); #1;
        rst = 1;
        @(posedge sys_clk); #1;
        rst = 0;
        repeat (3) @(posedge sys_clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
